// File: rtl/shadow_ret_stack.sv
// rtl/shadow_ret_stack.sv - shadow return-address stack that checks call/return pairing
// A return must target the link address of its matching call; a mismatch or true underflow raises a sticky alarm.
module shadow_ret_stack #(
    parameter int DEPTH = 8,
    parameter int VLEN  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic                       is_call_i,
    input  logic                       is_ret_i,
    input  logic [VLEN-1:0]            link_addr_i,
    input  logic [VLEN-1:0]            ret_target_i,
    input  logic                       clear_i,
    output logic                       violation_o,
    output logic [VLEN-1:0]            violation_addr_o,
    output logic [$clog2(DEPTH):0]     depth_o,
    output logic                       overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_ALARM = 1'b1;

    logic [VLEN-1:0] mem_q [DEPTH];
    logic [0:0]      state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            viol_q, viol_d;
    logic [VLEN-1:0] viol_addr_q, viol_addr_d;

    logic            ev;
    logic            viol;
    logic            mem_we;
    logic [PW-1:0]   mem_wa;
    logic [PW-1:0]   top;
    logic [PW-1:0]   ptr_pop;
    logic [CW-1:0]   cnt_pop;

    assign ev  = valid_i & en_i & (state_q == ST_RUN);
    assign top = wr_ptr_q - PW'(1);

    // The pop is resolved first so a same-cycle call reuses the slot the return just freed.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        viol_d      = viol_q;
        viol_addr_d = viol_addr_q;
        viol        = 1'b0;
        mem_we      = 1'b0;
        mem_wa      = wr_ptr_q;
        ptr_pop     = wr_ptr_q;
        cnt_pop     = count_q;

        if (ev && is_ret_i) begin
            if (count_q != '0) begin
                viol    = (mem_q[top] != ret_target_i);
                ptr_pop = top;
                cnt_pop = count_q - CW'(1);
            end else begin
                viol    = ~overflow_q;
            end
        end

        wr_ptr_d = ptr_pop;
        count_d  = cnt_pop;
        if (ev && is_call_i) begin
            mem_we   = 1'b1;
            mem_wa   = ptr_pop;
            wr_ptr_d = ptr_pop + PW'(1);
            if (cnt_pop == FULL) begin
                overflow_d = 1'b1;
            end else begin
                count_d = cnt_pop + CW'(1);
            end
        end

        if (viol) begin
            state_d     = ST_ALARM;
            viol_d      = 1'b1;
            viol_addr_d = ret_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            viol_q      <= 1'b0;
            viol_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            viol_q      <= viol_d;
            viol_addr_q <= viol_addr_d;
        end
    end

    // Storage is not reset; its contents only matter while count_q covers them.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i && !clear_i) begin
            mem_q[mem_wa] <= link_addr_i;
        end
    end

    assign violation_o      = viol_q;
    assign violation_addr_o = viol_addr_q;
    assign depth_o          = count_q;
    assign overflow_o       = overflow_q;
endmodule
